// File: rtl/arbiter8_pri_pkg.sv
// Shared types and constants for the eight-requester arbiter.
package arb_pkg;
  localparam int         NUM_REQ = 8;
  localparam logic [2:0] ID_NONE = 3'b111;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;
endpackage

// File: rtl/arbiter8_pri_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface arbiter8_pri_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] iReq_n;
  logic               iEn_n;
  logic [NUM_REQ-1:0] oGrant;
  logic [2:0]         oGrantId;
  logic               oBusy;
  logic               oTimeout;

  modport master (output iReq_n, iEn_n, input oGrant, oGrantId, oBusy, oTimeout);
  modport slave  (input iReq_n, iEn_n, output oGrant, oGrantId, oBusy, oTimeout);
endinterface

// File: rtl/arb_prio_pick.sv
// Combinational picker: first set bit of elig_i at or after start_i, wrapping 7->0.
module arb_prio_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [2:0]         start_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [2:0]         id_o,
  output logic               found_o
);
  always_comb begin
    logic [2:0] idx;
    idx     = '0;
    win_o   = '0;
    id_o    = ID_NONE;
    found_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = start_i + 3'(i);
      if (!found_o && elig_i[idx]) begin
        found_o    = 1'b1;
        id_o       = idx;
        win_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arbiter8_pri.sv
// Eight-requester arbiter with hold timeout and one turnaround cycle between owners.
// Define ARB_ROUND_ROBIN_EN for a rotating start pointer; default is fixed priority (bit 0 first).
module arbiter8_pri
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           iClk,
  input  logic           iRst_n,
  arbiter8_pri_if.slave  bus
);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [2:0]         id_q, id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               to_q, to_d;
  logic [2:0]         ptr;

  logic [NUM_REQ-1:0] elig, win;
  logic [2:0]         win_id;
  logic               found;
  logic               hold_done;

  assign elig      = ~bus.iReq_n & ~mask_q;
  assign hold_done = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1));

  arb_prio_pick u_pick (
    .elig_i  (elig),
    .start_i (ptr),
    .win_o   (win),
    .id_o    (win_id),
    .found_o (found)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  assign ptr = ptr_q;

  // Next search starts just past whoever just gave up the bus.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                                  ptr_q <= '0;
    else if (state_q == GRANT && state_d == TURN) ptr_q <= id_q + 3'd1;
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A timed-out owner sits out exactly one arbitration.
        mask_d = '0;
        if (!bus.iEn_n && found) begin
          grant_d = win;
          id_d    = win_id;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
        // Release/disable take precedence over a coincident timeout.
        if (bus.iReq_n[id_q] || bus.iEn_n || hold_done) begin
          state_d = TURN;
          grant_d = '0;
          id_d    = ID_NONE;
          if (!bus.iReq_n[id_q] && !bus.iEn_n) begin
            to_d   = 1'b1;
            mask_d = grant_q;
          end
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      mask_q  <= '0;
      id_q    <= ID_NONE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.oGrant   = grant_q;
  assign bus.oGrantId = id_q;
  assign bus.oBusy    = |grant_q;
  assign bus.oTimeout = to_q;
endmodule
